// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned WordWidth = 32;
  localparam logic [7:0]  SyncByteDefault = 8'hA5;

  typedef enum logic [2:0] {
    StSync,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian bytes into a 32-bit word and pulses word_done the cycle after lane 3 fills.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic [1:0]           byte_cnt,
  output logic [WordWidth-1:0] word,
  output logic                 word_done
);

  logic [WordWidth-1:0] lanes_q;
  logic [1:0]           byte_cnt_q;
  logic                 word_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q     <= '0;
      byte_cnt_q  <= '0;
      word_done_q <= 1'b0;
    end else if (clear) begin
      lanes_q     <= '0;
      byte_cnt_q  <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= byte_valid && (byte_cnt_q == 2'd3);
      if (byte_valid) begin
        lanes_q[8*byte_cnt_q +: 8] <= byte_data;
        byte_cnt_q                 <= byte_cnt_q + 2'd1;
      end
    end
  end

  // The word stays stable during the pulse since the next lane-0 byte lands on the same edge
  // that ends it.
  assign byte_cnt  = byte_cnt_q;
  assign word      = lanes_q;
  assign word_done = word_done_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/payload/CSUM frames, writes words to memory, gates core reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [AddrWidth-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned          MAX_WORDS = 16384,
  parameter logic [7:0]           SYNC_BYTE = SyncByteDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 start,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [WordWidth-1:0] mem_wdata,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned LastWordAddr = 32'(BASE_ADDR) + 4 * (MAX_WORDS - 1);

  if (MAX_WORDS == 0 || LastWordAddr > 32'hFFFC) begin : g_addr_range_check
    $error("prog_loader: BASE_ADDR + 4*MAX_WORDS overflows the 16-bit address space");
  end

  state_e         state_q, state_d;
  logic [15:0]    len_q;
  logic [15:0]    word_idx_q;
  logic [7:0]     csum_q;
  logic           transfer;
  logic           restart;
  logic [15:0]    hdr_len;
  logic [1:0]     byte_cnt;
  logic           last_word;

  assign transfer  = rx_valid && rx_ready;
  assign restart   = start && (state_q == StDone || state_q == StErr);
  assign hdr_len   = {rx_data, len_q[7:0]};
  assign last_word = (byte_cnt == 2'd3) && (word_idx_q == len_q - 16'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: if (transfer && rx_data == SYNC_BYTE) state_d = StLen0;
      StLen0: if (transfer) state_d = StLen1;
      StLen1: begin
        if (transfer) begin
          if (32'(hdr_len) > MAX_WORDS) state_d = StErr;
          else if (hdr_len == 16'd0)    state_d = StCsum;
          else                          state_d = StData;
        end
      end
      StData: if (transfer && last_word) state_d = StCsum;
      StCsum: if (transfer) state_d = (rx_data == csum_q) ? StDone : StErr;
      StDone: if (start) state_d = StSync;
      StErr:  if (start) state_d = StSync;
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSync;
      len_q      <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        len_q      <= '0;
        word_idx_q <= '0;
        csum_q     <= '0;
      end else begin
        if (transfer && state_q == StLen0) len_q[7:0] <= rx_data;
        if (transfer && state_q == StLen1) len_q <= hdr_len;
        if (transfer && state_q == StData) csum_q <= csum_q ^ rx_data;
        if (mem_we) word_idx_q <= word_idx_q + 16'd1;
      end
    end
  end

  prog_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_valid (transfer && state_q == StData),
    .byte_data  (rx_data),
    .byte_cnt   (byte_cnt),
    .word       (mem_wdata),
    .word_done  (mem_we)
  );

  // word_idx_q advances on the write edge, so it still names the word being written.
  assign mem_addr  = BASE_ADDR + {word_idx_q[13:0], 2'b00};
  assign rx_ready  = (state_q != StDone) && (state_q != StErr);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);
  assign core_hold = (state_q != StDone);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued and checked by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        start;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] exp_q[$];
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [47:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, e[47:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      for (int i = 0; i < 8 && $urandom_range(1, 0) == 1; i++) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    budget   = 0;
    while (!rx_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=0, required 1 within 20 cycles");
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'hXX;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) send_byte(frame[i], gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_test1(input logic [7:0] csum);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    frame[11] = csum;
  endtask

  task automatic push_test1_writes();
    exp_q.push_back({16'h0000, 32'h0000_0013});
    exp_q.push_back({16'h0004, 32'h0010_0093});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_error"},     32'(error),     32'd0);
  endtask

  task automatic check_status(input string tag, input bit d, input bit e);
    tick();
    check({tag, "_done"},      32'(done),      32'(d));
    check({tag, "_error"},     32'(error),     32'(e));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(!d));
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: two-word image, XOR of payload = 13^93^10 = 0x90.
    push_test1_writes();
    load_test1(8'h90);
    send_frame(1'b0);
    check_status("t1", 1'b1, 1'b0);

    // 2: junk before sync, empty image; start while loading is ignored, so re-arm first.
    pulse_start();
    check("t2_rearm_done", 32'(done), 32'd0);
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_status("t2", 1'b1, 1'b0);

    // 3: bad checksum still writes both words, then errors.
    pulse_start();
    push_test1_writes();
    load_test1(8'h91);
    send_frame(1'b0);
    check_status("t3", 1'b0, 1'b1);
    pulse_start();
    check("t3_rearm_error",    32'(error),     32'd0);
    check("t3_rearm_rx_ready", 32'(rx_ready),  32'd1);
    check("t3_rearm_hold",     32'(core_hold), 32'd1);

    // 4: N = MAX_WORDS+1 = 0x4001 errors right after LEN_HI.
    frame = '{8'hA5, 8'h01, 8'h40};
    send_frame(1'b0);
    check("t4_error_now", 32'(error), 32'd1);
    repeat (4) tick();
    check_status("t4", 1'b0, 1'b1);
    pulse_start();

    // 5: same image with random valid gaps.
    push_test1_writes();
    load_test1(8'h90);
    send_frame(1'b1);
    check_status("t5", 1'b1, 1'b0);
    pulse_start();

    // 6: reset after 6 payload bytes, then a clean resend.
    exp_q.push_back({16'h0000, 32'h0000_0013});
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_frame(1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_reset");
    tick();
    rst = 1'b0;
    tick();
    check("t6_pending_writes", exp_q.size(), 32'd0);
    push_test1_writes();
    load_test1(8'h90);
    send_frame(1'b0);
    check_status("t6", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
